// File: rtl/ap_hs_launcher.sv
// Driving end of the ap_start/ap_ready/ap_done/ap_continue block handshake. It launches a
// programmed number of transactions and reports per-transaction latency and start interval.
module ap_hs_launcher #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned LAT_W   = 32,
    parameter int unsigned MAX_OUT = 4,
    parameter int unsigned GAP_W   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cfg_start,
    input  logic [CNT_W-1:0] cfg_num_trans,
    input  logic [GAP_W-1:0] cfg_gap,
    input  logic             cont_stall,
    output logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    output logic             ap_continue,
    output logic             busy,
    output logic             run_done,
    output logic             lat_valid,
    output logic [CNT_W-1:0] lat_index,
    output logic [LAT_W-1:0] lat_value,
    output logic [LAT_W-1:0] ii_value,
    output logic             err_spurious
);

    localparam int unsigned PtrW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned OutW = $clog2(MAX_OUT + 1);

    typedef enum logic [2:0] {StIdle, StLaunch, StGap, StDrain, StFin} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] num_q, issued_q, comp_q;
    logic [GAP_W-1:0] gap_q, gap_cnt_q, gap_cnt_d;
    logic [OutW-1:0]  out_q, out_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LAT_W-1:0] ts_q [MAX_OUT];
    logic [LAT_W-1:0] iim_q [MAX_OUT];
    logic [LAT_W-1:0] now_q, last_acc_q, ii_now;
    logic             first_q, err_q, lat_valid_q;
    logic [CNT_W-1:0] lat_index_q;
    logic [LAT_W-1:0] lat_value_q, ii_value_q;
    logic             load, acc, dn, out_zero, bypass, push, pop, spurious;
    logic [CNT_W-1:0] issued_inc;

    assign ap_continue  = ~cont_stall;
    assign acc          = ap_start & ap_ready;
    assign dn           = ap_done & ap_continue;
    assign out_zero     = (out_q == '0);
    // A same-cycle accept and done with nothing outstanding never touches the FIFO.
    assign bypass       = acc & dn & out_zero;
    assign pop          = dn & ~out_zero;
    assign push         = acc & ~bypass;
    assign spurious     = dn & out_zero & ~acc;
    assign ii_now       = first_q ? '0 : now_q - last_acc_q;
    assign issued_inc   = issued_q + CNT_W'(1);
    assign lat_valid    = lat_valid_q;
    assign lat_index    = lat_index_q;
    assign lat_value    = lat_value_q;
    assign ii_value     = ii_value_q;
    assign err_spurious = err_q;

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        ap_start  = 1'b0;
        busy      = 1'b0;
        run_done  = 1'b0;
        load      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cfg_start) begin
                    load    = 1'b1;
                    state_d = (cfg_num_trans == '0) ? StFin : StLaunch;
                end
            end
            StLaunch: begin
                busy     = 1'b1;
                ap_start = (out_q < OutW'(MAX_OUT));
                if (acc) begin
                    if (issued_inc == num_q) begin
                        state_d = StDrain;
                    end else if (gap_q != '0) begin
                        state_d   = StGap;
                        gap_cnt_d = gap_q - GAP_W'(1);
                    end
                end
            end
            StGap: begin
                busy = 1'b1;
                if (gap_cnt_q == '0) state_d = StLaunch;
                else gap_cnt_d = gap_cnt_q - GAP_W'(1);
            end
            StDrain: begin
                busy = 1'b1;
                if (out_zero && !dn) state_d = StFin;
            end
            StFin: begin
                run_done = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        out_d    = out_q;
        if (push) wr_ptr_d = (wr_ptr_q == PtrW'(MAX_OUT - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_d = (rd_ptr_q == PtrW'(MAX_OUT - 1)) ? '0 : rd_ptr_q + PtrW'(1);
        if (push && !pop) out_d = out_q + OutW'(1);
        if (pop && !push) out_d = out_q - OutW'(1);
    end

    always_ff @(posedge clock) begin
        if (push) begin
            ts_q[wr_ptr_q]  <= now_q;
            iim_q[wr_ptr_q] <= ii_now;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            num_q       <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            issued_q    <= '0;
            comp_q      <= '0;
            out_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            now_q       <= '0;
            last_acc_q  <= '0;
            first_q     <= 1'b1;
            err_q       <= 1'b0;
            lat_valid_q <= 1'b0;
            lat_index_q <= '0;
            lat_value_q <= '0;
            ii_value_q  <= '0;
        end else begin
            state_q     <= state_d;
            gap_cnt_q   <= gap_cnt_d;
            out_q       <= out_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            now_q       <= now_q + LAT_W'(1);
            err_q       <= (err_q & ~load) | spurious;
            lat_valid_q <= pop | bypass;
            if (load) begin
                num_q    <= cfg_num_trans;
                gap_q    <= cfg_gap;
                issued_q <= '0;
                comp_q   <= '0;
                first_q  <= 1'b1;
            end
            if (acc) begin
                issued_q   <= issued_inc;
                last_acc_q <= now_q;
                first_q    <= 1'b0;
            end
            if (pop || bypass) begin
                comp_q      <= comp_q + CNT_W'(1);
                lat_index_q <= comp_q;
                lat_value_q <= bypass ? '0 : now_q - ts_q[rd_ptr_q];
                ii_value_q  <= bypass ? ii_now : iim_q[rd_ptr_q];
            end
        end
    end

endmodule

// File: tb/tb_ap_hs_launcher.sv
// Randomized bench for ap_hs_launcher: a child model drives the handshake and a
// transaction-level scoreboard predicts every output from the handshake rules.
module tb_ap_hs_launcher;

    localparam int CNT_W   = 8;
    localparam int LAT_W   = 10;
    localparam int MAX_OUT = 2;
    localparam int GAP_W   = 3;
    localparam int LMASK   = (1 << LAT_W) - 1;
    localparam int BIG     = 32'h7fff_ffff;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             cfg_start = 1'b0;
    logic [CNT_W-1:0] cfg_num_trans = '0;
    logic [GAP_W-1:0] cfg_gap = '0;
    logic             cont_stall = 1'b0;
    logic             ap_start;
    logic             ap_ready = 1'b0;
    logic             ap_done = 1'b0;
    logic             ap_continue, busy, run_done, lat_valid, err_spurious;
    logic [CNT_W-1:0] lat_index;
    logic [LAT_W-1:0] lat_value, ii_value;

    ap_hs_launcher #(
        .CNT_W  (CNT_W),
        .LAT_W  (LAT_W),
        .MAX_OUT(MAX_OUT),
        .GAP_W  (GAP_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .cfg_start    (cfg_start),
        .cfg_num_trans(cfg_num_trans),
        .cfg_gap      (cfg_gap),
        .cont_stall   (cont_stall),
        .ap_start     (ap_start),
        .ap_ready     (ap_ready),
        .ap_done      (ap_done),
        .ap_continue  (ap_continue),
        .busy         (busy),
        .run_done     (run_done),
        .lat_valid    (lat_valid),
        .lat_index    (lat_index),
        .lat_value    (lat_value),
        .ii_value     (ii_value),
        .err_spurious (err_spurious)
    );

    always #5 clock = ~clock;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    // Scoreboard state, in bench cycle numbers.
    int num_m, gap_m, issued, outst, comp_idx, last_acc, gap_until, busy_from, fin_at;
    bit first_m, err_m, exp_lv, chk_rst;
    int exp_idx, exp_lat, exp_ii;
    int ts_q[$];
    int ii_m[$];
    int child_q[$];

    // Child and stimulus knobs.
    int ready_pct = 100, stall_pct = 0, bypass_pct = 0, dmin = 1, dmax = 1;
    int stall_from = -1, stall_to = -1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        num_m = 0; gap_m = 0; issued = 0; outst = 0; comp_idx = 0; last_acc = 0;
        gap_until = 0; busy_from = BIG; fin_at = -1;
        first_m = 1; err_m = 0; exp_lv = 0;
        ts_q.delete(); ii_m.delete(); child_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clock);
        cyc++;
        reset = 1'b1; cfg_start = 1'b0; ap_ready = 1'b0; ap_done = 1'b0; cont_stall = 1'b0;
        model_clear();
        chk_rst = 1;
    endtask

    task automatic tick(input bit cfg, input int n, input int g, input bit spur);
        bit exp_start, rdy, stl, dne, acc, dn, byp;
        int ii_now, o0;
        @(negedge clock);
        cyc++;
        if (chk_rst) begin
            chk("rst_lat_index", lat_index, 0);
            chk("rst_lat_value", lat_value, 0);
            chk("rst_ii_value", ii_value, 0);
            chk_rst = 0;
        end
        chk("lat_valid", lat_valid, exp_lv);
        if (exp_lv) begin
            chk("lat_index", lat_index, exp_idx);
            chk("lat_value", lat_value, exp_lat);
            chk("ii_value", ii_value, exp_ii);
        end
        chk("err_spurious", err_spurious, err_m);
        exp_start = (issued < num_m) && (cyc >= gap_until) && (outst < MAX_OUT);
        chk("ap_start", ap_start, exp_start);
        chk("busy", busy, (cyc >= busy_from) && (cyc < fin_at));
        chk("run_done", run_done, cyc == fin_at);

        rdy = ($urandom_range(99) < ready_pct);
        stl = ($urandom_range(99) < stall_pct) || (cyc >= stall_from && cyc < stall_to);
        dne = (child_q.size() > 0) && (child_q[0] <= cyc);
        if (exp_start && outst == 0 && child_q.size() == 0 && $urandom_range(99) < bypass_pct) begin
            rdy = 1; stl = 0; dne = 1;
        end
        if (spur) begin
            dne = 1; stl = 0;
        end
        reset = 1'b0; cfg_start = cfg; cfg_num_trans = n[CNT_W-1:0]; cfg_gap = g[GAP_W-1:0];
        ap_ready = rdy; ap_done = dne; cont_stall = stl;
        #1 chk("ap_continue", ap_continue, !stl);

        acc = exp_start && rdy;
        dn = dne && !stl;
        o0 = outst;
        byp = acc && dn && (o0 == 0);
        exp_lv = 0;
        if (cfg && cyc > fin_at) begin
            num_m = n; gap_m = g; issued = 0; comp_idx = 0; first_m = 1; err_m = 0;
            busy_from = cyc + 1; gap_until = cyc + 1;
            fin_at = (n == 0) ? cyc + 1 : BIG;
        end
        ii_now = first_m ? 0 : ((cyc - last_acc) & LMASK);
        if (dn) begin
            if (o0 == 0 && !acc) begin
                err_m = 1;
            end else begin
                exp_lv = 1;
                exp_idx = comp_idx & ((1 << CNT_W) - 1);
                comp_idx++;
                if (byp) begin
                    exp_lat = 0;
                    exp_ii = ii_now;
                end else begin
                    exp_lat = (cyc - ts_q.pop_front()) & LMASK;
                    exp_ii = ii_m.pop_front();
                    void'(child_q.pop_front());
                    outst--;
                end
            end
        end
        if (acc) begin
            first_m = 0; last_acc = cyc; issued++; gap_until = cyc + gap_m + 1;
            if (!byp) begin
                ts_q.push_back(cyc);
                ii_m.push_back(ii_now);
                child_q.push_back(cyc + int'($urandom_range(dmax, dmin)));
                outst++;
            end
        end
        if (exp_lv && issued == num_m && outst == 0) fin_at = cyc + 2;
    endtask

    task automatic run_once(input int n, input int g, input bit noise);
        int budget;
        tick(1, n, g, 0);
        budget = 0;
        while (!(cyc > fin_at) && budget < 600) begin
            tick(noise && (cyc + 1 < fin_at) && $urandom_range(19) == 0,
                 int'($urandom_range(7)), int'($urandom_range(7)), 0);
            budget++;
        end
        if (budget >= 600) begin
            chk("run_timeout", 1, 0);
            do_reset();
        end
    endtask

    initial begin
        model_clear();
        repeat (3) @(negedge clock);
        do_reset();

        // Back-to-back launch, fixed latency 5, limited by two outstanding.
        ready_pct = 100; dmin = 5; dmax = 5;
        run_once(3, 0, 0);
        dmin = 10; dmax = 10;
        run_once(4, 0, 0);
        dmin = 1; dmax = 1;
        run_once(2, 3, 0);

        // Done held under a 6-cycle continue stall.
        dmin = 2; dmax = 2;
        stall_from = cyc + 4; stall_to = cyc + 10;
        run_once(1, 0, 0);
        stall_from = -1; stall_to = -1;

        // Empty run, then a done while idle.
        run_once(0, 0, 0);
        tick(0, 0, 0, 1);
        repeat (4) tick(0, 0, 0, 0);

        // Randomized runs; the cycle counter wraps several times along the way.
        for (int r = 0; r < 60; r++) begin
            ready_pct  = int'($urandom_range(100, 30));
            stall_pct  = int'($urandom_range(40));
            bypass_pct = int'($urandom_range(1)) * 30;
            dmin       = int'($urandom_range(3, 1));
            dmax       = dmin + int'($urandom_range(18));
            run_once(int'($urandom_range(7)), ($urandom_range(1) == 0) ? 0 : int'($urandom_range(7)), 1);
            stall_pct = 0;
            for (int k = int'($urandom_range(3)); k > 0; k--) tick(0, 0, 0, $urandom_range(5) == 0);
        end

        // Reset in the middle of a launch sequence, then a clean run.
        ready_pct = 100; stall_pct = 0; bypass_pct = 0; dmin = 8; dmax = 8;
        tick(1, 7, 0, 0);
        repeat (3) tick(0, 0, 0, 0);
        do_reset();
        repeat (2) tick(0, 0, 0, 0);
        dmin = 1; dmax = 4;
        run_once(3, 1, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
